// File: rtl/encoder_serial.sv
// Serialising one-hot/multi-hot encoder: accepts a WIDTH-bit vector and emits one set-bit index per beat.
// Optional ENCODER_SERIAL_COUNT_EN adds a registered popcount output (set_count).
module encoder_serial #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0,
    parameter int IDX_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] encode_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] encode_out,
    output logic             out_last,
    output logic             out_zero,
    output logic             busy
`ifdef ENCODER_SERIAL_COUNT_EN
    ,
    output logic [IDX_W:0]   set_count
`endif
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] pending, pending_next;
    logic             zero_flag, zero_next;
    logic [WIDTH-1:0] sel_mask;
    logic [IDX_W-1:0] sel_idx;
    logic             single;

    // Last write in each loop wins, so the scan direction picks the opposite end.
    always_comb begin
        sel_idx  = '0;
        sel_mask = '0;
        if (MSB_FIRST) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (pending[i]) begin
                    sel_idx     = IDX_W'(i);
                    sel_mask    = '0;
                    sel_mask[i] = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = WIDTH; i > 0; i--) begin
                if (pending[i-1]) begin
                    sel_idx       = IDX_W'(i - 1);
                    sel_mask      = '0;
                    sel_mask[i-1] = 1'b1;
                end
            end
        end
    end

    assign single = ((pending & (pending - 1'b1)) == '0);

    always_comb begin
        state_next   = state;
        pending_next = pending;
        zero_next    = zero_flag;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        out_zero     = 1'b0;
        encode_out   = '0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                in_ready = enable & rst_n;
                if (enable && in_valid) begin
                    pending_next = encode_in;
                    zero_next    = (encode_in == '0);
                    state_next   = DRAIN;
                end
            end
            DRAIN: begin
                out_valid  = 1'b1;
                busy       = 1'b1;
                encode_out = sel_idx;
                out_zero   = zero_flag;
                out_last   = zero_flag | single;
                if (!enable) begin
                    state_next   = IDLE;
                    pending_next = '0;
                    zero_next    = 1'b0;
                end else if (out_ready) begin
                    pending_next = pending & ~sel_mask;
                    if (zero_flag || single) begin
                        state_next   = IDLE;
                        pending_next = '0;
                        zero_next    = 1'b0;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
                zero_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            zero_flag <= zero_next;
        end
    end

`ifdef ENCODER_SERIAL_COUNT_EN
    logic [IDX_W:0] popcount;

    always_comb begin
        popcount = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            popcount = popcount + (IDX_W+1)'(encode_in[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            set_count <= '0;
        end else if (state == IDLE && state_next == DRAIN) begin
            set_count <= popcount;
        end else if (state_next == IDLE) begin
            set_count <= '0;
        end
    end
`endif

endmodule
